axi_write_burst_slave: RTL

Parametrised AXI4 write-channel slave endpoint that terminates AW/W/B traffic and turns each burst into single-beat writes on a simple local write port (register banks, memory wrappers). It generalises the SoC write bus with burst address generation (FIXED/INCR/WRAP), a buffered address channel for outstanding bursts, and a real write response (BRESP) with error signalling. It sits between the interconnect master port and each peripheral's register file.

---
 rtl/axi_write_burst_slave.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_write_burst_slave.sv
// AXI4 write-channel slave: queues AW bursts, expands each burst into single-beat
// local writes with FIXED/INCR/WRAP addressing, and returns a per-burst BRESP.
module axi_write_burst_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned AW_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LOW  = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_HIGH = ADDR_WIDTH'(32'hFFFF_FFFF)
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [8*DATA_BYTES-1:0]   WDATA,
    input  logic [DATA_BYTES-1:0]     WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic [ADDR_WIDTH-1:0]     wr_addr_o,
    output logic [8*DATA_BYTES-1:0]   wr_data_o,
    output logic [DATA_BYTES-1:0]     wr_strb_o,
    output logic                      wr_valid_o,
    input  logic                      wr_ready_i,
    input  logic                      wr_error_i
);

    localparam int unsigned PTR_WIDTH = $clog2(AW_DEPTH);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;
    localparam int unsigned MAX_SIZE  = $clog2(DATA_BYTES);
    localparam logic [ADDR_WIDTH:0] ADDR_SPAN = {1'b0, ADDR_HIGH - ADDR_LOW};

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } aw_entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // Address FIFO
    aw_entry_t             fifo_mem [AW_DEPTH];
    aw_entry_t             head;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  fifo_cnt;
    logic [CNT_WIDTH-1:0]  fifo_cnt_nxt;
    logic                  fifo_empty;
    logic                  aw_push;
    logic                  aw_pop;
    logic                  awready_q;

    // Burst context
    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [7:0]            beat_q;
    logic                  err_q;
    logic                  size_bad_q;

    logic                  head_wrap_ok;
    logic                  head_burst_bad;
    logic                  head_size_bad;
    logic [1:0]            head_eff_burst;
    logic                  in_range;
    logic                  beat_legal;
    logic                  last_beat;
    logic                  beat_acc;
    logic                  beat_err;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    assign head         = fifo_mem[rd_ptr];
    assign fifo_empty   = (fifo_cnt == '0);
    assign aw_push      = AWVALID && awready_q;
    assign fifo_cnt_nxt = fifo_cnt + CNT_WIDTH'(aw_push) - CNT_WIDTH'(aw_pop);
    assign AWREADY      = awready_q;

    // Payload storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge ACLK) begin
        if (aw_push) begin
            fifo_mem[wr_ptr] <= '{addr: AWADDR, len: AWLEN, size: AWSIZE, burst: AWBURST};
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            awready_q <= 1'b0;
        end else begin
            if (aw_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (aw_pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            fifo_cnt  <= fifo_cnt_nxt;
            awready_q <= (fifo_cnt_nxt != CNT_WIDTH'(AW_DEPTH));
        end
    end

    // Burst-level checks on the entry being popped; bad WRAP/reserved degrade to INCR.
    assign head_wrap_ok   = (head.len == 8'd1) || (head.len == 8'd3) ||
                            (head.len == 8'd7) || (head.len == 8'd15);
    assign head_burst_bad = (head.burst == BURST_RSVD) ||
                            ((head.burst == BURST_WRAP) && !head_wrap_ok);
    assign head_size_bad  = (head.size > 3'(MAX_SIZE));
    assign head_eff_burst = head_burst_bad ? BURST_INCR : head.burst;

    // Per-beat legality and next-address generation
    assign in_range   = ({1'b0, addr_q - ADDR_LOW} <= ADDR_SPAN);
    assign beat_legal = !size_bad_q && in_range;
    assign last_beat  = (beat_q == len_q);
    assign beat_acc   = (state == S_BURST) && WVALID && WREADY;
    assign beat_err   = !beat_legal || wr_error_i || (WLAST != last_beat);

    assign step      = ADDR_WIDTH'(1) << size_q;
    assign incr_addr = addr_q + step;
    assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);

    always_comb begin
        addr_nxt = incr_addr;
        case (burst_q)
            BURST_FIXED: addr_nxt = addr_q;
            BURST_WRAP:  addr_nxt = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     addr_nxt = incr_addr;
        endcase
    end

    // FSM state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state; a pop also loads the burst context below
    always_comb begin
        state_nxt = state;
        aw_pop    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    aw_pop    = 1'b1;
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (beat_acc && last_beat) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (BREADY) begin
                    if (!fifo_empty) begin
                        aw_pop    = 1'b1;
                        state_nxt = S_BURST;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; illegal beats are swallowed without a local write
    always_comb begin
        WREADY     = 1'b0;
        wr_valid_o = 1'b0;
        BVALID     = 1'b0;
        BRESP      = RESP_OKAY;
        case (state)
            S_BURST: begin
                if (beat_legal) begin
                    wr_valid_o = WVALID;
                    WREADY     = wr_ready_i;
                end else begin
                    WREADY     = 1'b1;
                end
            end
            S_RESP: begin
                BVALID = 1'b1;
                BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

    // Burst context: loaded on pop, advanced on every accepted beat
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= BURST_FIXED;
            beat_q     <= '0;
            err_q      <= 1'b0;
            size_bad_q <= 1'b0;
        end else if (aw_pop) begin
            addr_q     <= head.addr;
            len_q      <= head.len;
            size_q     <= head.size;
            burst_q    <= head_eff_burst;
            beat_q     <= '0;
            err_q      <= head_burst_bad || head_size_bad;
            size_bad_q <= head_size_bad;
        end else if (beat_acc) begin
            addr_q <= addr_nxt;
            beat_q <= beat_q + 8'd1;
            if (beat_err) err_q <= 1'b1;
        end
    end

    assign wr_addr_o = addr_q;
    assign wr_data_o = WDATA;
    assign wr_strb_o = WSTRB;

endmodule
